// File: rtl/csync_pulse.sv
//------------------------------------------------------------------------------
// csync_pulse : active-low composite sync from separate hsync/vsync, with
//               serration pulses sized to the last measured hsync-low width.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module csync_pulse #(
  parameter int CNT_WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic hsync,
  input  logic vsync,
  output logic csync
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 h_q;
  logic                 h_d;
  logic                 v_q;
  logic [CNT_WIDTH-1:0] wcnt;
  logic [CNT_WIDTH-1:0] w_meas;
  logic [CNT_WIDTH-1:0] pcnt;
  logic                 fall;
  logic                 rise;

  assign fall = h_d & ~h_q;
  assign rise = ~h_d & h_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= 1'b1;
      h_d <= 1'b1;
      v_q <= 1'b1;
    end else begin
      h_q <= hsync;
      h_d <= h_q;
      v_q <= vsync;
    end
  end

  // Low-time counter; its value at the rising edge is the hsync width.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt   <= '0;
      w_meas <= '0;
    end else begin
      if (h_q) begin
        wcnt <= '0;
      end else if (wcnt != CNT_MAX) begin
        wcnt <= wcnt + CNT_ONE;
      end
      if (rise) begin
        w_meas <= wcnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csync <= 1'b1;
      pcnt  <= '0;
    end else if (v_q) begin
      csync <= h_q;
      pcnt  <= '0;
    end else if (w_meas == '0) begin
      // No width known yet: invert hsync so serrations still appear.
      csync <= ~h_q;
      pcnt  <= '0;
    end else if (fall) begin
      csync <= 1'b1;
      pcnt  <= w_meas - CNT_ONE;
    end else if (pcnt != '0) begin
      csync <= 1'b1;
      pcnt  <= pcnt - CNT_ONE;
    end else begin
      csync <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csync_pulse.sv
//------------------------------------------------------------------------------
// tb_csync_pulse : randomized and directed self-checking bench for csync_pulse.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_csync_pulse;

  localparam int CW   = 5;
  localparam int WMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic hsync;
  logic vsync;
  logic csync;

  int vectors = 0;
  int errors  = 0;

  // Input values sampled by the DUT at each clock edge since reset release.
  bit hs_q[$];
  bit vs_q[$];

  csync_pulse #(.CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .hsync (hsync),
    .vsync (vsync),
    .csync (csync)
  );

  always #5 clk = ~clk;

  function automatic bit hs_at(input int k);
    if (k < 0) return 1'b1;
    return hs_q[k];
  endfunction

  // Width of the most recent hsync-low run that has completed and been
  // registered by cycle k (zero if none yet).
  function automatic int model_w(input int k);
    int run;
    for (int r = k - 1; r >= 0; r--) begin
      if (hs_at(r) == 1'b1 && hs_at(r - 1) == 1'b0) begin
        run = 0;
        for (int i = r - 1; i >= 0 && hs_q[i] == 1'b0; i--) run++;
        return (run > WMAX) ? WMAX : run;
      end
    end
    return 0;
  endfunction

  // csync that the DUT must present one edge after cycle k.
  function automatic bit model_csync(input int k);
    int wf;
    if (k < 0) return 1'b1;
    if (vs_q[k]) return hs_q[k];
    if (model_w(k) == 0) return !hs_q[k];
    for (int f = k; f >= 0; f--) begin
      if (vs_q[f]) return 1'b0;
      if (hs_q[f] == 1'b0 && hs_at(f - 1) == 1'b1) begin
        wf = model_w(f);
        return (wf > 0) && ((k - f) < wf);
      end
    end
    return 1'b0;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int n;
    bit exp;
    n   = hs_q.size();
    exp = (n < 2) ? 1'b1 : model_csync(n - 2);
    vectors++;
    if (csync !== exp) begin
      errors++;
      $display("FAIL csync_cycle %0d: got %b expected %b", n, csync, exp);
    end
  end

  task automatic step(input bit h, input bit v);
    hsync = h;
    vsync = v;
    @(posedge clk);
    if (!rst) begin
      hs_q.push_back(h);
      vs_q.push_back(v);
    end
    #1;
  endtask

  // One line starting at the hsync fall; returns csync-high samples seen.
  task automatic line(input bit v, input int lo, input int hi, output int highs);
    highs = 0;
    for (int i = 0; i < lo; i++) begin
      step(1'b0, v);
      if (csync === 1'b1) highs++;
    end
    for (int i = 0; i < hi; i++) begin
      step(1'b1, v);
      if (csync === 1'b1) highs++;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    @(posedge clk);
    #1;
    hs_q.delete();
    vs_q.delete();
    @(posedge clk);
    #1;
    check("reset_csync", csync, 1);
    rst = 1'b0;
  endtask

  initial begin
    int  highs;
    int  lo;
    int  hi;
    bit  v;

    rst   = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_csync", csync, 1);
    rst = 1'b0;

    // Normal lines
    repeat (32) step(1'b1, 1'b1);
    line(1'b1, 8, 32, highs);
    check("model_w_after_line1", model_w(hs_q.size()), 8);
    check("normal_line1_highs", highs, 32);
    line(1'b1, 8, 32, highs);
    line(1'b1, 8, 32, highs);
    check("normal_line3_highs", highs, 32);
    line(1'b1, 8, 32, highs);

    // Vertical lines: the first one still carries the normal-mode tail
    line(1'b0, 8, 32, highs);
    for (int l = 0; l < 3; l++) begin
      line(1'b0, 8, 32, highs);
      check($sformatf("vert_line%0d_highs", l + 6), highs, 8);
    end

    // Vertical exit
    line(1'b1, 8, 32, highs);
    check("exit_line_highs", highs, 31);

    // Mid-pulse exit three clocks into the serration
    repeat (3) step(1'b1, 1'b0);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      step((i < 8) ? 1'b0 : 1'b1, (i < 3) ? 1'b0 : 1'b1);
      if (csync === 1'b1) highs++;
    end
    check("midpulse_exit_highs", highs, 34);

    // Saturation
    line(1'b1, 40, 20, highs);
    check("model_w_saturated", model_w(hs_q.size()), WMAX);
    repeat (3) step(1'b1, 1'b0);
    line(1'b0, 8, 32, highs);
    check("sat_pulse_highs", highs, WMAX);
    line(1'b0, 8, 32, highs);
    check("after_sat_pulse_highs", highs, 8);

    // Randomized lines with occasional vsync toggles
    v = 1'b1;
    for (int l = 0; l < 50; l++) begin
      lo = int'($urandom_range(1, 40));
      hi = int'($urandom_range(1, 40));
      for (int i = 0; i < lo + hi; i++) begin
        if ($urandom_range(0, 49) == 0) v = ~v;
        step((i < lo) ? 1'b0 : 1'b1, v);
      end
    end

    // Fallback before any measurement
    do_reset();
    line(1'b0, 6, 10, highs);
    check("fallback_line_highs", highs, 7);
    line(1'b0, 6, 10, highs);
    check("first_measured_highs", highs, 6);

    repeat (4) step(1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/csync_pulse.md
Name:
csync_pulse

Overview:
- Builds an active-low composite sync (csync) from separate active-low hsync and vsync inputs, as found on the video output path of the Atari console.
- Outside vertical sync, csync follows hsync.
- During vertical sync, csync is held low except for a regenerated positive serration pulse at each hsync falling edge.
- The pulse width equals the most recently measured hsync-low width, so the block adapts to the incoming line timing.

Parameters:
- CNT_WIDTH, default 5: width of the hsync-width measurement register and the pulse counter. Measured widths saturate at 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- hsync  input  1  horizontal sync, active low, synchronous to clk.
- vsync  input  1  vertical sync, active low, synchronous to clk.
- csync  output  1  composite sync, active low, registered.

Behaviour:
- Interface (already decided): one clock (clk); reset (rst) is synchronous and active-high.
- Input stage:
  - h_q <= hsync, h_d <= h_q, v_q <= vsync.
  - fall = h_d & ~h_q; rise = ~h_d & h_q.
- Width measurement:
  - wcnt clears to 0 while h_q=1.
  - wcnt increments each clock while h_q=0, saturating at all-ones.
  - On rise, W <= wcnt. W therefore holds the number of clocks hsync was low (8 for an 8-clock pulse).
  - W persists across vsync mode changes.
- Normal mode (v_q=1): csync <= h_q; any pulse in progress is cancelled (pcnt <= 0).
- Vertical mode (v_q=0):
  - On fall with W>0: csync <= 1 and pcnt <= W-1.
  - Else if pcnt>0: csync stays 1 and pcnt decrements.
  - Else: csync <= 0.
  - Result: csync is high for exactly W clocks starting at each hsync fall and low for the rest of the line.
  - On fall with W=0 (no measurement yet): csync <= ~h_q, an XNOR fallback, for as long as W stays 0.
  - A fall that arrives while a pulse is active restarts the pulse with W-1.
- Latency: an input change sampled at edge n appears on csync at edge n+1, i.e. 2 clocks from pin to output.
- Mode switches take effect on the clock after v_q changes.
  - Entering vertical mode mid-line, with no fall pending, drives csync low immediately.
  - Leaving vertical mode mid-pulse truncates the pulse; csync then follows h_q.
- Saturation: an hsync low longer than 2^CNT_WIDTH-1 clocks yields W = 2^CNT_WIDTH-1.
- Reset, taking priority over all else:
  - csync=1.
  - h_q=h_d=1, v_q=1.
  - wcnt=0, W=0, pcnt=0.
  - The first line after reset, and any vertical period before a complete hsync pulse has been measured, uses the W=0 fallback.

Test Plan:
- Reset then idle: rst=1 for 2 clocks with hsync=vsync=1 -> csync=1 during and after reset.
- Normal lines: 32 clocks hsync=1 then 8 clocks hsync=0, repeated 3 times, vsync=1 -> csync is a copy of hsync delayed 2 clocks (8 clocks low per line); W=8 after the first rise.
- Vertical mode: vsync=0 asserted at the end of line 4, lines unchanged -> per line, csync high for exactly 8 clocks starting 2 clocks after the hsync fall, low for the other 32 clocks.
- Vertical exit: vsync=1 raised at the end of line 8 -> normal behaviour resumes on the next clock; csync is again a 2-clock-delayed copy of hsync.
- Mid-pulse exit plus saturation:
  - Drop vsync to 1 three clocks into a serration pulse -> pulse truncated and csync follows h_q.
  - Then, with CNT_WIDTH=5, hold hsync low 40 clocks -> W=31 and the next vertical pulse is 31 clocks wide.
- No-measurement fallback: assert vsync=0 immediately after reset, before any hsync pulse -> csync = ~hsync delayed 2 clocks until the first complete hsync pulse has been measured.
